// File: rtl/indication_output_queue.sv
// ---------------------------------------------------------------------------
// indication_output_queue
//
// Collects indication words from NUM_CH source channels through a round-robin
// arbiter and forwards them, in acceptance order, through a DEPTH-entry FIFO
// onto a single valid/ready output pipe. Each stored word carries the index of
// the channel it came from (tag), its method ID and its payload.
//
// Optional build macro:
//   INDICATION_OUTPUT_QUEUE_STATS_EN  - adds the sent_count port, a 32-bit
//                                       wrapping count of delivered words.
//
// Ports:
//   CLK         in   1                     clock, all state on posedge
//   nRST        in   1                     synchronous active-low reset
//   ind_ena     in   NUM_CH                per-channel indication valid
//   ind_rdy     out  NUM_CH                per-channel accept (one-hot or 0)
//   ind_meth    in   NUM_CH*METH_WIDTH     method IDs, channel i at slice i
//   ind_v       in   NUM_CH*DATA_WIDTH     payloads, channel i at slice i
//   pipe_ena    out  1                     head word valid
//   pipe_rdy    in   1                     downstream accept
//   pipe_tag    out  TAG_W                 source channel of head word
//   pipe_meth   out  METH_WIDTH            method ID of head word
//   pipe_v      out  DATA_WIDTH            payload of head word
//   count       out  CNT_W                 queue occupancy, 0..DEPTH
//   sent_count  out  32                    delivered words (STATS_EN only)
// ---------------------------------------------------------------------------
module indication_output_queue #(
    parameter  int NUM_CH     = 2,
    parameter  int DEPTH      = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int METH_WIDTH = 8,
    localparam int TAG_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [NUM_CH-1:0]            ind_ena,
    output logic [NUM_CH-1:0]            ind_rdy,
    input  logic [NUM_CH*METH_WIDTH-1:0] ind_meth,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ind_v,
    output logic                         pipe_ena,
    input  logic                         pipe_rdy,
    output logic [TAG_W-1:0]             pipe_tag,
    output logic [METH_WIDTH-1:0]        pipe_meth,
    output logic [DATA_WIDTH-1:0]        pipe_v,
    output logic [CNT_W-1:0]             count
`ifdef INDICATION_OUTPUT_QUEUE_STATS_EN
    ,
    output logic [31:0]                  sent_count
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [METH_WIDTH-1:0] meth;
        logic [DATA_WIDTH-1:0] v;
    } entry_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [TAG_W-1:0]  rr_ptr;

    // -----------------------------------------------------------------------
    // Channel slices unpacked so the winner can select them by index
    // -----------------------------------------------------------------------
    logic [METH_WIDTH-1:0] meth_arr [NUM_CH];
    logic [DATA_WIDTH-1:0] v_arr    [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign meth_arr[i] = ind_meth[i*METH_WIDTH +: METH_WIDTH];
        assign v_arr[i]    = ind_v[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // -----------------------------------------------------------------------
    // Status
    // -----------------------------------------------------------------------
    logic full;
    logic empty;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // -----------------------------------------------------------------------
    // Round-robin arbiter
    // Search starts at rr_ptr and walks upward, wrapping at NUM_CH. rr_ptr is
    // always < NUM_CH, so a single conditional subtract is enough to wrap.
    // -----------------------------------------------------------------------
    function automatic int rr_index(input logic [TAG_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        return (s >= NUM_CH) ? (s - NUM_CH) : s;
    endfunction

    logic [NUM_CH-1:0] grant;
    logic [TAG_W-1:0]  winner;
    logic              found;

    // NOTE: every signal driven here gets a default before the loop; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && ind_ena[rr_index(rr_ptr, k)]) begin
                grant[rr_index(rr_ptr, k)] = 1'b1;
                winner                     = TAG_W'(rr_index(rr_ptr, k));
                found                      = 1'b1;
            end
        end
    end

    // Pointer the arbiter will start from after this cycle's winner.
    logic [TAG_W-1:0] next_rr;
    assign next_rr = (winner == TAG_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;

    // -----------------------------------------------------------------------
    // Handshakes
    // Outputs are forced idle while nRST is low so that nothing is offered or
    // accepted during the reset cycle, even though the registers only clear
    // at the edge that ends it.
    // -----------------------------------------------------------------------
    logic push;
    logic pop;

    assign ind_rdy  = (nRST && !full) ? grant : '0;
    assign push     = |ind_rdy;
    assign pipe_ena = nRST && !empty;
    assign pop      = pipe_ena && pipe_rdy;
    assign count    = nRST ? count_q : '0;

    // -----------------------------------------------------------------------
    // Head of queue. Contents are undefined while empty; pipe_ena is low then.
    // -----------------------------------------------------------------------
    entry_t head;
    assign head      = mem[rd_ptr];
    assign pipe_tag  = head.tag;
    assign pipe_meth = head.meth;
    assign pipe_v    = head.v;

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rr_ptr  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= next_rr;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Push and pop in the same cycle leave the occupancy unchanged.
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Storage
    // NOTE: the data array is deliberately not reset; occupancy and pointers
    // define which entries are meaningful, and leaving the array unreset lets
    // it map onto plain RAM/register-file cells.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= '{tag: winner, meth: meth_arr[winner], v: v_arr[winner]};
        end
    end

`ifdef INDICATION_OUTPUT_QUEUE_STATS_EN
    // -----------------------------------------------------------------------
    // Delivered-word counter, wraps naturally at 2^32.
    // -----------------------------------------------------------------------
    logic [31:0] sent_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            sent_q <= '0;
        end else if (pop) begin
            sent_q <= sent_q + 32'd1;
        end
    end

    assign sent_count = sent_q;
`endif

endmodule

// File: doc/indication_output_queue.md
INDICATION_OUTPUT_QUEUE -- requirements
Module: indication_output_queue

Interface
REQ-001 Parameter NUM_CH, default 2: number of indication source channels, 1..8.
REQ-002 Parameter DEPTH, default 4: output queue entries, power of two, >=2.
REQ-003 Parameter DATA_WIDTH, default 32: payload width per indication.
REQ-004 Parameter METH_WIDTH, default 8: method-ID width per indication.
REQ-005 Derived TAG_W = max(1, clog2(NUM_CH)); CNT_W = clog2(DEPTH)+1.
REQ-006 Reset nRST, synchronous, active-low; clock CLK; all state changes on posedge CLK.
REQ-007 CLK  in  1  clock.
REQ-008 nRST  in  1  synchronous active-low reset.
REQ-009 ind_ena  in  NUM_CH  per-channel indication valid.
REQ-010 ind_rdy  out  NUM_CH  per-channel accept (one-hot or zero).
REQ-011 ind_meth  in  NUM_CH*METH_WIDTH  method ID, channel i at slice i.
REQ-012 ind_v  in  NUM_CH*DATA_WIDTH  payload, channel i at slice i.
REQ-013 pipe_ena  out  1  output word valid.
REQ-014 pipe_rdy  in  1  downstream accept.
REQ-015 pipe_tag  out  TAG_W  source channel index of head word.
REQ-016 pipe_meth  out  METH_WIDTH  method ID of head word.
REQ-017 pipe_v  out  DATA_WIDTH  payload of head word.
REQ-018 count  out  CNT_W  current queue occupancy, 0..DEPTH.
REQ-019 sent_count  out  32  words delivered (present only with REQ-035 macro).

Function
REQ-020 Enqueue transfer on channel i SHALL occur iff ind_ena[i] && ind_rdy[i] at a clock edge.
REQ-021 ind_rdy[i] SHALL equal (count != DEPTH) && grant[i]; grant one-hot, round-robin among asserted ind_ena starting at rr_ptr, zero if no request.
REQ-022 At most one enqueue per cycle; rr_ptr SHALL become (winner+1) mod NUM_CH after a transfer, unchanged otherwise.
REQ-023 Enqueued entry stores {tag=i, ind_meth slice i, ind_v slice i} at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-024 pipe_ena SHALL equal (count != 0); pipe_tag/meth/v SHALL present entry at rd_ptr.
REQ-025 Dequeue on pipe_ena && pipe_rdy; rd_ptr increments modulo DEPTH.
REQ-026 No bypass: word accepted in cycle N SHALL first be visible on pipe_* in cycle N+1 (minimum latency 1).
REQ-027 While pipe_ena && !pipe_rdy, pipe_tag/meth/v SHALL hold stable.
REQ-028 Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
REQ-029 Full (count==DEPTH): all ind_rdy low even if a dequeue occurs that cycle; enqueue resumes next cycle.
REQ-030 Empty: pipe_ena low, pipe_rdy ignored, pipe_* data don't-care.
REQ-031 Output order SHALL equal acceptance order (FIFO) across all channels.

Reset
REQ-032 On nRST low at posedge: count=0, wr_ptr=rd_ptr=0, rr_ptr=0, sent_count=0; queue contents don't-care.
REQ-033 Reset outputs: pipe_ena=0, ind_rdy=0 during reset cycle, count=0.
REQ-034 Reset mid-operation SHALL discard all queued words; no transfer completes in the reset cycle.

Configuration
REQ-035 Macro INDICATION_OUTPUT_QUEUE_STATS_EN defined: sent_count port present, increments by 1 per dequeue, wraps 0xFFFFFFFF->0.
REQ-036 Macro undefined: sent_count port and counter absent; all other behaviour identical.

Verification (NUM_CH=2, DEPTH=4, DATA_WIDTH=32, METH_WIDTH=8)
REQ-037 Single word: ch0 ena, meth=0x01, v=0xDEADBEEF, pipe_rdy=1 -> next cycle pipe_ena=1, tag=0, meth=0x01, v=0xDEADBEEF; following cycle count=0.
REQ-038 Contention: both channels ena every cycle, rr_ptr=0 -> accepted tags 0,1,0,1; pipe outputs same order.
REQ-039 Full: pipe_rdy=0, ch1 sends 5 words -> 4 accepted, count=4, ind_rdy=00 while full; pipe_rdy=1 one cycle -> count=3, 5th word accepted next cycle.
REQ-040 Backpressure: pipe_rdy toggled 0/1 over 4 queued words -> pipe_* stable while stalled, words 0..3 delivered in order, none lost or duplicated.
REQ-041 Reset mid-stream: count=3, assert nRST low one cycle -> count=0, pipe_ena=0, rr_ptr=0, sent_count=0 (STATS_EN build).
REQ-042 Wrap: 10 words through with pipe_rdy=1 -> pointer wrap correct, sent_count=10 with STATS_EN.
